// File: rtl/bram_pkg.sv
// Shared types for the true dual-port byte-enable block RAM.
package bram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        WRITE_FIRST,
        READ_FIRST,
        NO_CHANGE
    } rdw_mode_t;

endpackage

// File: rtl/bram_out_stage.sv
// Optional per-port output register; data holds when no result arrives.
module bram_out_stage
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EN         = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_d;
    logic                  valid_q;

    always_comb begin
        data_d  = i_valid ? i_data : data_q;
        valid_d = i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Unused flops fold away when the stage is bypassed.
    assign o_data  = (EN != 0) ? data_q  : i_data;
    assign o_valid = (EN != 0) ? valid_q : i_valid;

endmodule

// File: rtl/bram_tdp_be.sv
// True dual-port block RAM with byte enables, selectable read-during-write
// behaviour and an optional output register.
module bram_tdp_be
    import bram_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter int        ADDR_WIDTH = 10,
    parameter int        RAM_SIZE   = 1 << ADDR_WIDTH,
    parameter rdw_mode_t RDW_MODE   = WRITE_FIRST,
    parameter int        OUT_REG    = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en_a,
    input  logic                    i_en_b,
    input  logic [DATA_WIDTH/8-1:0] i_we_a,
    input  logic [DATA_WIDTH/8-1:0] i_we_b,
    input  logic [ADDR_WIDTH-1:0]   i_addr_a,
    input  logic [ADDR_WIDTH-1:0]   i_addr_b,
    input  logic [DATA_WIDTH-1:0]   i_data_a,
    input  logic [DATA_WIDTH-1:0]   i_data_b,
    output logic [DATA_WIDTH-1:0]   o_data_a,
    output logic [DATA_WIDTH-1:0]   o_data_b,
    output logic                    o_valid_a,
    output logic                    o_valid_b,
    output logic                    o_collision
);

    localparam int NB    = DATA_WIDTH / BYTE_W;
    localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] RANGE = (ADDR_WIDTH + 1)'(RAM_SIZE);

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    logic                  acc_a, acc_b;
    logic                  wr_a, wr_b;
    logic                  inr_a, inr_b;
    logic                  same;
    logic [IDX_W-1:0]      idx_a, idx_b;
    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] rd_data_a_d, rd_data_a_q;
    logic [DATA_WIDTH-1:0] rd_data_b_d, rd_data_b_q;
    logic                  rd_valid_a_d, rd_valid_a_q;
    logic                  rd_valid_b_d, rd_valid_b_q;
    logic                  coll_d, coll_q;
    logic                  coll2_q;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         we
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int k = 0; k < NB; k++) begin
            if (we[k]) res[BYTE_W*k +: BYTE_W] = new_w[BYTE_W*k +: BYTE_W];
        end
        return res;
    endfunction

    always_comb begin
        acc_a = i_en_a && !i_rst;
        acc_b = i_en_b && !i_rst;
        wr_a  = acc_a && (i_we_a != '0);
        wr_b  = acc_b && (i_we_b != '0);
        inr_a = ({1'b0, i_addr_a} < RANGE);
        inr_b = ({1'b0, i_addr_b} < RANGE);
        idx_a = i_addr_a[IDX_W-1:0];
        idx_b = i_addr_b[IDX_W-1:0];
        same  = inr_a && inr_b && (i_addr_a == i_addr_b);
        old_a = inr_a ? mem[idx_a] : '0;
        old_b = inr_b ? mem[idx_b] : '0;

        rd_valid_a_d = acc_a && !((RDW_MODE == NO_CHANGE) && wr_a);
        rd_valid_b_d = acc_b && !((RDW_MODE == NO_CHANGE) && wr_b);

        // A write from the other port always yields the pre-write word.
        rd_data_a_d = rd_data_a_q;
        if (rd_valid_a_d) begin
            if (!inr_a || (same && wr_b) || !wr_a || (RDW_MODE != WRITE_FIRST))
                rd_data_a_d = old_a;
            else
                rd_data_a_d = merge(old_a, i_data_a, i_we_a);
        end

        rd_data_b_d = rd_data_b_q;
        if (rd_valid_b_d) begin
            if (!inr_b || (same && wr_a) || !wr_b || (RDW_MODE != WRITE_FIRST))
                rd_data_b_d = old_b;
            else
                rd_data_b_d = merge(old_b, i_data_b, i_we_b);
        end

        coll_d = acc_a && acc_b && same && (wr_a || wr_b);
    end

    // Port A is applied last so it wins bytes both ports enable.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NB; k++) begin
            if (wr_b && inr_b && i_we_b[k])
                mem[idx_b][BYTE_W*k +: BYTE_W] <= i_data_b[BYTE_W*k +: BYTE_W];
            if (wr_a && inr_a && i_we_a[k])
                mem[idx_a][BYTE_W*k +: BYTE_W] <= i_data_a[BYTE_W*k +: BYTE_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            coll_q       <= 1'b0;
            coll2_q      <= 1'b0;
        end else begin
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            coll_q       <= coll_d;
            coll2_q      <= coll_q;
        end
    end

    assign o_collision = (OUT_REG != 0) ? coll2_q : coll_q;

    bram_out_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .EN        (OUT_REG)
    ) u_out_a (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (rd_data_a_q),
        .i_valid(rd_valid_a_q),
        .o_data (o_data_a),
        .o_valid(o_valid_a)
    );

    bram_out_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .EN        (OUT_REG)
    ) u_out_b (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (rd_data_b_q),
        .i_valid(rd_valid_b_q),
        .o_data (o_data_b),
        .o_valid(o_valid_b)
    );

endmodule

// File: tb/tb_bram_tdp_be.sv
// Bench: three RAM variants driven in lockstep, checked against a memory model.
module tb_bram_tdp_be;
    import bram_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int RS   = 12;
    localparam int NI   = 3;
    localparam int NCYC = 512;
    localparam rdw_mode_t MODES [NI] = '{WRITE_FIRST, READ_FIRST, NO_CHANGE};
    localparam int LATS [NI] = '{1, 2, 1};

    logic          clk = 1'b0;
    logic          rst;
    logic          en_a, en_b;
    logic [3:0]    we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;

    logic [DW-1:0] od_a [NI];
    logic [DW-1:0] od_b [NI];
    logic          ov_a [NI];
    logic          ov_b [NI];
    logic          oc   [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bram_tdp_be #(
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW),
            .RAM_SIZE  (RS),
            .RDW_MODE  (MODES[g]),
            .OUT_REG   (LATS[g] - 1)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_en_a     (en_a),
            .i_en_b     (en_b),
            .i_we_a     (we_a),
            .i_we_b     (we_b),
            .i_addr_a   (addr_a),
            .i_addr_b   (addr_b),
            .i_data_a   (data_a),
            .i_data_b   (data_b),
            .o_data_a   (od_a[g]),
            .o_data_b   (od_b[g]),
            .o_valid_a  (ov_a[g]),
            .o_valid_b  (ov_b[g]),
            .o_collision(oc[g])
        );
    end

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: memory image plus per-cycle access results, shifted by latency.
    logic [DW-1:0] mem_m [16];
    logic          h_rst [NCYC];
    logic          h_c   [NCYC];
    logic          h_v   [NCYC][NI][2];
    logic [DW-1:0] h_d   [NCYC][NI][2];
    logic [DW-1:0] exp_d [NI][2];
    int            cyc = 0;

    initial begin
        for (int k = 0; k < 16; k++) mem_m[k] = 'x;
        for (int i = 0; i < NI; i++) begin
            exp_d[i][0] = '0;
            exp_d[i][1] = '0;
        end
    end

    function automatic void port_res(
        input  rdw_mode_t     m,
        input  logic          acc,
        input  logic          wr,
        input  logic          inr,
        input  logic          other_hits,
        input  logic [3:0]    we,
        input  logic [DW-1:0] wd,
        input  logic [DW-1:0] old,
        output logic          v,
        output logic [DW-1:0] d
    );
        v = acc && !(m == NO_CHANGE && wr);
        d = old;
        if (!inr) d = '0;
        else if (!other_hits && wr && m == WRITE_FIRST)
            for (int k = 0; k < 4; k++)
                if (we[k]) d[8*k +: 8] = wd[8*k +: 8];
    endfunction

    always @(posedge clk) begin : model
        logic          aa, ab, wa, wb, ra, rb, hit_a, hit_b;
        logic [DW-1:0] old_a, old_b, d, ed;
        logic          v, ev, ec, flush;
        int            src;
        aa = en_a && !rst;
        ab = en_b && !rst;
        wa = aa && (we_a != 0);
        wb = ab && (we_b != 0);
        ra = (int'(addr_a) < RS);
        rb = (int'(addr_b) < RS);
        old_a = ra ? mem_m[addr_a] : '0;
        old_b = rb ? mem_m[addr_b] : '0;
        hit_a = wb && rb && ra && addr_a == addr_b;
        hit_b = wa && ra && rb && addr_a == addr_b;
        if (cyc < NCYC) begin
            h_rst[cyc] = rst;
            h_c[cyc] = aa && ab && ra && addr_a == addr_b && (wa || wb);
            for (int i = 0; i < NI; i++) begin
                port_res(MODES[i], aa, wa, ra, hit_a, we_a, data_a, old_a, v, d);
                h_v[cyc][i][0] = v;
                h_d[cyc][i][0] = d;
                port_res(MODES[i], ab, wb, rb, hit_b, we_b, data_b, old_b, v, d);
                h_v[cyc][i][1] = v;
                h_d[cyc][i][1] = d;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (wb && rb && we_b[k]) mem_m[addr_b][8*k +: 8] = data_b[8*k +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            if (wa && ra && we_a[k]) mem_m[addr_a][8*k +: 8] = data_a[8*k +: 8];
        end
        #1;
        if (cyc < NCYC) begin
            for (int i = 0; i < NI; i++) begin
                src = cyc - LATS[i] + 1;
                flush = (src < 0);
                for (int k = (src < 0 ? 0 : src); k <= cyc; k++)
                    if (h_rst[k]) flush = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (flush) begin
                        ev = 1'b0;
                        ed = '0;
                    end else begin
                        ev = h_v[src][i][p];
                        ed = ev ? h_d[src][i][p] : exp_d[i][p];
                    end
                    exp_d[i][p] = ed;
                    chk($sformatf("c%0d_u%0d_p%0d_valid", cyc, i, p),
                        {31'd0, p == 0 ? ov_a[i] : ov_b[i]}, {31'd0, ev});
                    if (!$isunknown(ed))
                        chk($sformatf("c%0d_u%0d_p%0d_data", cyc, i, p),
                            p == 0 ? od_a[i] : od_b[i], ed);
                end
                ec = flush ? 1'b0 : h_c[src];
                chk($sformatf("c%0d_u%0d_coll", cyc, i), {31'd0, oc[i]}, {31'd0, ec});
            end
        end
        cyc++;
    end

    task automatic idle();
        en_a = 0; en_b = 0; we_a = 0; we_b = 0;
        addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
    endtask

    task automatic pa(input logic [3:0] a, input logic [3:0] we,
                      input logic [DW-1:0] d);
        en_a = 1; addr_a = a; we_a = we; data_a = d;
    endtask

    task automatic pb(input logic [3:0] a, input logic [3:0] we,
                      input logic [DW-1:0] d);
        en_b = 1; addr_b = a; we_b = we; data_b = d;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        repeat (3) tick();
        chk("rst_data_a", od_a[0], 32'h0);
        chk("rst_valid_a", {31'd0, ov_a[1]}, 32'h0);
        chk("rst_coll", {31'd0, oc[0]}, 32'h0);
        rst = 0;
        for (int i = 0; i < RS; i++) begin
            pa(4'(i), 4'hF, 32'hA500_0000 + i);
            tick();
        end

        pa(5, 4'hF, 32'hDEAD_BEEF); tick();
        chk("wf_full", od_a[0], 32'hDEAD_BEEF);
        pa(5, 4'b0010, 32'h0000_AA00); tick();
        chk("wf_merge", od_a[0], 32'hDEAD_AAEF);
        chk("wf_merge_valid", {31'd0, ov_a[0]}, 32'h1);
        pb(5, 0, 0); tick();
        chk("b_read5", od_b[0], 32'hDEAD_AAEF);
        chk("a_hold", od_a[0], 32'hDEAD_AAEF);
        chk("a_idle_valid", {31'd0, ov_a[0]}, 32'h0);

        pa(3, 4'hF, 32'h1111_1111); tick();
        pa(3, 0, 0); tick();
        chk("nc_read", od_a[2], 32'h1111_1111);
        pa(3, 4'hF, 32'h2222_2222); tick();
        chk("nc_hold", od_a[2], 32'h1111_1111);
        chk("nc_valid", {31'd0, ov_a[2]}, 32'h0);
        chk("wf_new", od_a[0], 32'h2222_2222);
        tick();
        chk("rf_old", od_a[1], 32'h1111_1111);
        chk("rf_valid", {31'd0, ov_a[1]}, 32'h1);

        pa(7, 4'b0011, 32'hAAAA_AAAA);
        pb(7, 4'b1110, 32'hBBBB_BBBB);
        tick();
        chk("coll_pulse", {31'd0, oc[0]}, 32'h1);
        chk("dual_a_prewrite", od_a[0], 32'hA500_0007);
        pa(7, 0, 0); tick();
        chk("coll_once", {31'd0, oc[0]}, 32'h0);
        chk("dual_merge", od_a[0], 32'hBBBB_AAAA);

        pa(0, 0, 0); tick();
        pa(1, 0, 0); tick();
        chk("or_rd0", od_a[1], 32'hA500_0000);
        chk("or_v0", {31'd0, ov_a[1]}, 32'h1);
        pa(2, 0, 0); tick();
        chk("or_rd1", od_a[1], 32'hA500_0001);
        chk("or_v1", {31'd0, ov_a[1]}, 32'h1);
        tick();
        chk("or_rd2", od_a[1], 32'hA500_0002);
        chk("or_v2", {31'd0, ov_a[1]}, 32'h1);
        tick();
        chk("or_v_end", {31'd0, ov_a[1]}, 32'h0);

        pa(13, 0, 0); tick();
        chk("oor_data", od_a[0], 32'h0);
        chk("oor_valid", {31'd0, ov_a[0]}, 32'h1);
        pa(13, 4'hF, 32'h1234_5678);
        pb(13, 4'hF, 32'h8765_4321);
        tick();
        chk("oor_no_coll", {31'd0, oc[0]}, 32'h0);

        pa(9, 0, 0); pb(9, 0, 0); tick();
        rst = 1;
        pa(4, 4'hF, 32'hFFFF_0000);
        tick();
        chk("rst_drop_data", od_a[1], 32'h0);
        chk("rst_drop_valid", {31'd0, ov_a[1]}, 32'h0);
        chk("rst_out_b", od_b[0], 32'h0);
        tick();
        rst = 0;
        pa(4, 0, 0); pb(9, 0, 0); tick();
        chk("rst_addr4_kept", od_a[0], 32'hA500_0004);
        chk("rst_addr9_kept", od_b[0], 32'hA500_0009);
        chk("rst_after_v", {31'd0, ov_a[1]}, 32'h0);
        tick();
        chk("rst_addr4_or", od_a[1], 32'hA500_0004);

        repeat (80) begin
            if ($urandom_range(0, 3) != 0)
                pa(4'($urandom), $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom);
            if ($urandom_range(0, 3) != 0)
                pb(4'($urandom_range(0, 1) ? 32'(addr_a) : $urandom),
                   $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom);
            tick();
        end
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
